// File: rtl/alu_slice_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer and its environment.
// Holds FSM state encodings, the slice width and the ALU function codes that
// the bench and integrators use to select add and xor on the 4-bit slice.
package alu_slice_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Function codes for the external 4-bit slice (S select, M mode).
    localparam logic [3:0] ALU_ADD_S = 4'b1001;
    localparam logic       ALU_ADD_M = 1'b0;
    localparam logic [3:0] ALU_XOR_S = 4'b0110;
    localparam logic       ALU_XOR_M = 1'b1;

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Bundle of command, result and slice-drive signals around the sequencer.
// master: the sequencer's view (drives cmd_ready, res_*, alu_a/b/s/m/pin).
// slave : the environment's view (control FSM drives cmd_*/res_ready, slice drives alu_r/alu_p).
interface alu_slice_sequencer_if #(
    parameter int WIDTH = 16
);
    import alu_slice_sequencer_pkg::*;

    // command side
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WIDTH-1:0]   cmd_a;
    logic [WIDTH-1:0]   cmd_b;
    logic [3:0]         cmd_s;
    logic               cmd_m;
    logic               cmd_cin;

    // result side
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_r;
    logic               res_cout;
    logic               res_zero;

    // slice side
    logic [SLICE_W-1:0] alu_a;
    logic [SLICE_W-1:0] alu_b;
    logic [3:0]         alu_s;
    logic               alu_m;
    logic               alu_pin;
    logic [SLICE_W-1:0] alu_r;
    logic [3:0]         alu_p;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin,
        output cmd_ready,
        output res_valid, res_r, res_cout, res_zero,
        input  res_ready,
        output alu_a, alu_b, alu_s, alu_m, alu_pin,
        input  alu_r, alu_p
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_s, cmd_m, cmd_cin,
        input  cmd_ready,
        input  res_valid, res_r, res_cout, res_zero,
        output res_ready,
        input  alu_a, alu_b, alu_s, alu_m, alu_pin,
        output alu_r, alu_p
    );

endinterface

// File: rtl/alu_slice_sequencer.sv
// Runs one WIDTH-bit operation through an external 4-bit ALU slice, one nibble per clock, LSB first.
// Latency: accept edge plus NSLICE slice edges (5 edges for WIDTH=16); one command in flight.
// Backpressure: cmd_ready only in IDLE; result held stable in HOLD until res_ready, no same-cycle turnaround.
// Ports: clk, rst (sync, active-high); bus (master modport): cmd_* in, res_* out, alu_* drive/return of the slice.
module alu_slice_sequencer
    import alu_slice_sequencer_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_slice_sequencer_if.master  bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic               load, step, last;
    logic               cmd_ready, res_valid;

    // Operands are kept as shift registers so the current nibble always sits
    // at the bottom; they stop shifting on the final slice so alu_a/alu_b
    // keep their last values through HOLD and IDLE.
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [3:0]         s_q;
    logic               m_q;
    logic               carry_q;     // doubles as the alu_pin driver
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   res_q, res_next;
    logic               res_cout_q, res_zero_q;

    // Only the slice carry-out takes part in the chain.
    logic               unused_alu_p;
    assign unused_alu_p = ^bus.alu_p[2:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result with the current slice's nibble merged in; used both for the
    // register update and for the zero flag on the final slice.
    always_comb begin
        res_next = res_q;
        res_next[int'(idx_q)*SLICE_W +: SLICE_W] = bus.alu_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            s_q        <= '0;
            m_q        <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            res_q      <= '0;
            res_cout_q <= 1'b0;
            res_zero_q <= 1'b0;
        end else if (load) begin
            a_sh    <= bus.cmd_a;
            b_sh    <= bus.cmd_b;
            s_q     <= bus.cmd_s;
            m_q     <= bus.cmd_m;
            carry_q <= bus.cmd_cin;
            idx_q   <= '0;
        end else if (step) begin
            res_q <= res_next;
            if (last) begin
                // Carry is forwarded regardless of mode; the slice decides its meaning.
                res_cout_q <= bus.alu_p[3];
                res_zero_q <= (res_next == '0);
            end else begin
                a_sh    <= a_sh >> SLICE_W;
                b_sh    <= b_sh >> SLICE_W;
                carry_q <= bus.alu_p[3];
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_r     = res_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.alu_a     = a_sh[SLICE_W-1:0];
    assign bus.alu_b     = b_sh[SLICE_W-1:0];
    assign bus.alu_s     = s_q;
    assign bus.alu_m     = m_q;
    assign bus.alu_pin   = carry_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer paired with a behavioural 4-bit slice (add / xor).
// Expected results come from whole-word arithmetic on the operands.
// Covers reset, add, overflow, xor, backpressure, mid-run reset, back-to-back and random ops.
module tb_alu_slice_sequencer;
    import alu_slice_sequencer_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;
    localparam int LAT    = NSLICE + 1;
    localparam int BOUND  = 50;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural slice: add with carry, or xor with no carry.
    logic [4:0] slice_sum;
    always_comb begin
        slice_sum  = '0;
        bus.alu_r  = 4'h0;
        bus.alu_p  = 4'h0;
        if (bus.alu_m == ALU_ADD_M && bus.alu_s == ALU_ADD_S) begin
            slice_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_pin};
            bus.alu_r = slice_sum[3:0];
            bus.alu_p = {slice_sum[4], 3'b000};
        end else if (bus.alu_m == ALU_XOR_M && bus.alu_s == ALU_XOR_S) begin
            bus.alu_r = bus.alu_a ^ bus.alu_b;
        end
    end

    // Whole-word reference.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic m, input logic cin,
                                  output logic [WIDTH-1:0] r, output logic c, output logic z);
        logic [WIDTH:0] full;
        if (m == ALU_ADD_M) full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        else                full = {1'b0, a ^ b};
        r = full[WIDTH-1:0];
        c = full[WIDTH];
        z = (full[WIDTH-1:0] == '0);
    endfunction

    // Carry into bit 4*i of a + b + cin.
    function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic cin, input int i);
        logic [WIDTH:0] mask, sum;
        mask = ({{WIDTH{1'b0}}, 1'b1} << (4*i)) - 1'b1;
        sum  = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{WIDTH{1'b0}}, cin};
        return sum[4*i];
    endfunction

    function automatic logic [3:0] nib(input logic [WIDTH-1:0] v, input int i);
        logic [WIDTH-1:0] t;
        t = v >> (4*i);
        return t[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [3:0] s, input logic m, input logic cin);
        bus.cmd_a   = a;
        bus.cmd_b   = b;
        bus.cmd_s   = s;
        bus.cmd_m   = m;
        bus.cmd_cin = cin;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic scramble_cmd();
        bus.cmd_valid = 1'b0;
        bus.cmd_a   = WIDTH'($urandom);
        bus.cmd_b   = WIDTH'($urandom);
        bus.cmd_s   = 4'($urandom);
        bus.cmd_m   = 1'($urandom);
        bus.cmd_cin = 1'($urandom);
    endtask

    // Issue one command, wait for the result, take it. lat counts edges from
    // the accepting edge (inclusive) to the edge that raised res_valid.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic m, input logic cin,
                         output logic [WIDTH-1:0] r, output logic c, output logic z,
                         output int lat);
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < BOUND) begin tick(); w++; end
        drive_cmd(a, b, (m == ALU_ADD_M) ? ALU_ADD_S : ALU_XOR_S, m, cin);
        tick();
        scramble_cmd();
        lat = 1;
        while (bus.res_valid !== 1'b1 && lat < BOUND) begin tick(); lat++; end
        r = bus.res_r;
        c = bus.res_cout;
        z = bus.res_zero;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        vectors++; if (bus.res_r !== '0) begin miscompares++; $display("FAIL reset_res_r: got %h want 0", bus.res_r); end
        vectors++; if (bus.res_cout !== 1'b0) begin miscompares++; $display("FAIL reset_res_cout: got %b want 0", bus.res_cout); end
        vectors++; if (bus.res_zero !== 1'b0) begin miscompares++; $display("FAIL reset_res_zero: got %b want 0", bus.res_zero); end
        vectors++; if ({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_pin} !== '0) begin
            miscompares++;
            $display("FAIL reset_alu_outputs: got a=%h b=%h s=%h m=%b pin=%b want all 0",
                     bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_pin);
        end
        rst = 1'b0;
        tick();
    endtask

    // Directed add with per-slice carry ripple and latency check.
    task automatic test_add();
        logic [WIDTH-1:0] a, b, er;
        logic ec, ez;
        a = 16'h0FFF; b = 16'h0001;
        model(a, b, ALU_ADD_M, 1'b0, er, ec, ez);
        drive_cmd(a, b, ALU_ADD_S, ALU_ADD_M, 1'b0);
        tick();
        scramble_cmd();
        for (int i = 0; i < NSLICE; i++) begin
            vectors++; if (bus.alu_pin !== carry_into(a, b, 1'b0, i)) begin
                miscompares++; $display("FAIL add_carry_in_slice%0d: got %b want %b", i, bus.alu_pin, carry_into(a, b, 1'b0, i));
            end
            vectors++; if (bus.alu_a !== nib(a, i) || bus.alu_b !== nib(b, i)) begin
                miscompares++; $display("FAIL add_nibble_slice%0d: got a=%h b=%h want a=%h b=%h", i, bus.alu_a, bus.alu_b, nib(a, i), nib(b, i));
            end
            vectors++; if (bus.res_valid !== 1'b0) begin
                miscompares++; $display("FAIL add_early_valid_slice%0d: got %b want 0", i, bus.res_valid);
            end
            tick();
        end
        // NSLICE edges after the accepting edge: LAT edges in total.
        vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: res_valid %b after %0d edges, want 1", bus.res_valid, LAT); end
        vectors++; if (bus.res_r !== er) begin miscompares++; $display("FAIL add_res_r: got %h want %h", bus.res_r, er); end
        vectors++; if (bus.res_cout !== ec) begin miscompares++; $display("FAIL add_res_cout: got %b want %b", bus.res_cout, ec); end
        vectors++; if (bus.res_zero !== ez) begin miscompares++; $display("FAIL add_res_zero: got %b want %b", bus.res_zero, ez); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] r;
        logic c, z;
        int lat;
        do_op(16'hFFFF, 16'h0001, ALU_ADD_M, 1'b0, r, c, z, lat);
        vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL ovf_res_r: got %h want 0000", r); end
        vectors++; if (c !== 1'b1) begin miscompares++; $display("FAIL ovf_res_cout: got %b want 1", c); end
        vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL ovf_res_zero: got %b want 1", z); end
        vectors++; if (lat != LAT) begin miscompares++; $display("FAIL ovf_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_xor();
        logic [WIDTH-1:0] a, b, er;
        logic ec, ez;
        a = 16'hA5A5; b = 16'h5A5A;
        model(a, b, ALU_XOR_M, 1'b0, er, ec, ez);
        drive_cmd(a, b, ALU_XOR_S, ALU_XOR_M, 1'b0);
        tick();
        scramble_cmd();
        for (int i = 0; i < NSLICE; i++) begin
            vectors++; if (bus.alu_m !== 1'b1 || bus.alu_s !== ALU_XOR_S) begin
                miscompares++; $display("FAIL xor_fn_slice%0d: got m=%b s=%b want m=1 s=0110", i, bus.alu_m, bus.alu_s);
            end
            tick();
        end
        vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL xor_valid: got %b want 1", bus.res_valid); end
        vectors++; if (bus.res_r !== er) begin miscompares++; $display("FAIL xor_res_r: got %h want %h", bus.res_r, er); end
        vectors++; if (bus.res_cout !== ec) begin miscompares++; $display("FAIL xor_res_cout: got %b want %b", bus.res_cout, ec); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] er, a2, b2;
        logic ec, ez, cin2;
        int w;
        model(16'h1234, 16'h4321, ALU_ADD_M, 1'b1, er, ec, ez);
        drive_cmd(16'h1234, 16'h4321, ALU_ADD_S, ALU_ADD_M, 1'b1);
        tick();
        scramble_cmd();
        w = 0;
        while (bus.res_valid !== 1'b1 && w < BOUND) begin tick(); w++; end
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid = i[0];
            bus.cmd_a = WIDTH'($urandom);
            bus.cmd_b = WIDTH'($urandom);
            bus.cmd_cin = 1'($urandom);
            vectors++; if (bus.res_valid !== 1'b1 || bus.res_r !== er || bus.res_cout !== ec || bus.res_zero !== ez) begin
                miscompares++;
                $display("FAIL bp_hold_cycle%0d: got v=%b r=%h c=%b z=%b want v=1 r=%h c=%b z=%b",
                         i, bus.res_valid, bus.res_r, bus.res_cout, bus.res_zero, er, ec, ez);
            end
            vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_cmd_ready_cycle%0d: got %b want 0", i, bus.cmd_ready); end
            tick();
        end
        a2 = WIDTH'($urandom); b2 = WIDTH'($urandom); cin2 = 1'($urandom);
        drive_cmd(a2, b2, ALU_ADD_S, ALU_ADD_M, cin2);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", bus.res_valid); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_no_turnaround: cmd_ready %b want 1", bus.cmd_ready); end
        tick();
        scramble_cmd();
        vectors++; if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_accept_next: cmd_ready %b want 0", bus.cmd_ready); end
        model(a2, b2, ALU_ADD_M, cin2, er, ec, ez);
        w = 1;
        while (bus.res_valid !== 1'b1 && w < BOUND) begin tick(); w++; end
        vectors++; if (w != LAT) begin miscompares++; $display("FAIL bp_second_latency: got %0d want %0d", w, LAT); end
        vectors++; if (bus.res_r !== er || bus.res_cout !== ec) begin
            miscompares++; $display("FAIL bp_second_result: got r=%h c=%b want r=%h c=%b", bus.res_r, bus.res_cout, er, ec);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] r;
        logic c, z;
        int lat, pulses;
        drive_cmd(16'hFFFF, 16'h0001, ALU_ADD_S, ALU_ADD_M, 1'b1);
        tick();              // accept; first RUN cycle
        scramble_cmd();
        tick();              // second RUN cycle
        tick();              // third RUN cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_cmd_ready: got %b want 1", bus.cmd_ready); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_res_valid: got %b want 0", bus.res_valid); end
        vectors++; if (bus.res_r !== '0 || bus.res_cout !== 1'b0 || bus.res_zero !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_res: got r=%h c=%b z=%b want 0", bus.res_r, bus.res_cout, bus.res_zero);
        end
        vectors++; if ({bus.alu_a, bus.alu_b, bus.alu_pin} !== '0) begin
            miscompares++; $display("FAIL rstmid_alu: got a=%h b=%h pin=%b want 0", bus.alu_a, bus.alu_b, bus.alu_pin);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.res_valid === 1'b1) pulses++;
            tick();
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rstmid_no_pulse: got %0d valid cycles want 0", pulses); end
        do_op(16'h0002, 16'h0003, ALU_ADD_M, 1'b0, r, c, z, lat);
        vectors++; if (r !== 16'h0005 || c !== 1'b0 || z !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_followup: got r=%h c=%b z=%b want r=0005 c=0 z=0", r, c, z);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] rq[$];
        logic cq[$], zq[$];
        logic acc;
        int sent;
        sent = 0;
        bus.res_ready = 1'b1;
        drive_cmd(16'h1111, 16'h2222, ALU_ADD_S, ALU_ADD_M, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (acc) begin
                sent++;
                if (sent == 1) drive_cmd(16'h8000, 16'h8000, ALU_ADD_S, ALU_ADD_M, 1'b0);
                else           scramble_cmd();
            end
            if (bus.res_valid === 1'b1) begin
                rq.push_back(bus.res_r);
                cq.push_back(bus.res_cout);
                zq.push_back(bus.res_zero);
            end
        end
        bus.res_ready = 1'b0;
        vectors++; if (rq.size() != 2) begin miscompares++; $display("FAIL b2b_pulse_count: got %0d want 2", rq.size()); end
        if (rq.size() >= 1) begin
            vectors++; if (rq[0] !== 16'h3333 || cq[0] !== 1'b0) begin
                miscompares++; $display("FAIL b2b_first: got r=%h c=%b want r=3333 c=0", rq[0], cq[0]);
            end
        end
        if (rq.size() >= 2) begin
            vectors++; if (rq[1] !== 16'h0000 || cq[1] !== 1'b1 || zq[1] !== 1'b1) begin
                miscompares++; $display("FAIL b2b_second: got r=%h c=%b z=%b want r=0000 c=1 z=1", rq[1], cq[1], zq[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, r, er;
        logic m, cin, c, z, ec, ez;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            m = 1'($urandom); cin = 1'($urandom);
            if (i % 8 == 7) b = ~a;      // exercise zero / all-ones results
            model(a, b, m, cin, er, ec, ez);
            do_op(a, b, m, cin, r, c, z, lat);
            vectors++; if (r !== er) begin miscompares++; $display("FAIL rand%0d_res_r: a=%h b=%h m=%b cin=%b got %h want %h", i, a, b, m, cin, r, er); end
            vectors++; if (c !== ec) begin miscompares++; $display("FAIL rand%0d_res_cout: got %b want %b", i, c, ec); end
            vectors++; if (z !== ez) begin miscompares++; $display("FAIL rand%0d_res_zero: got %b want %b", i, z, ez); end
            vectors++; if (lat != LAT) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, LAT); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_s = '0;
        bus.cmd_m = 1'b0;
        bus.cmd_cin = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_add();
        test_overflow();
        test_xor();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
Multi-cycle initiator that runs one WIDTH-bit operation through the 4-bit combinational ALU slice, one nibble per clock, LSB first. Carry is chained between slices through a register. Sits between the central unit's control FSM, which provides the command/result handshake, and a single ALU slice instance, which is driven through the alu_* ports. Replaces a wide parallel ALU with one time-multiplexed slice.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NSLICE, WIDTH/4, derived slice count; not to be overridden.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_s  in  4  ALU function select, held for the whole operation
cmd_m  in  1  ALU mode (1 = logic, 0 = arithmetic)
cmd_cin  in  1  carry into slice 0
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_r  out  WIDTH  assembled result
res_cout  out  1  carry out of the last slice (alu_p[3] of slice NSLICE-1)
res_zero  out  1  res_r == 0
alu_a  out  4  current A nibble to the slice
alu_b  out  4  current B nibble
alu_s  out  4  function select to the slice
alu_m  out  1  mode to the slice
alu_pin  out  1  carry into the slice
alu_r  in  4  slice result (combinational)
alu_p  in  4  slice carry/propagate vector; bit 3 = slice carry out

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- States: IDLE, RUN, HOLD.
- Reset values: state=IDLE; cmd_ready=1; res_valid=0; res_r=0; res_cout=0; res_zero=0; all alu_* outputs=0; slice index=0; carry register=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1: latch cmd_a, cmd_b, cmd_s, cmd_m. Load the carry register with cmd_cin. Set index=0. Go to RUN.
- RUN:
  - cmd_ready=0.
  - Outputs are driven from registers: alu_a = A[4*idx+3:4*idx], alu_b = the same nibble of B, alu_s/alu_m = latched values, alu_pin = carry register.
  - Each cycle: write alu_r into res_r[4*idx+3:4*idx] and alu_p[3] into the carry register, then increment idx.
  - When idx == NSLICE-1: capture the final nibble, set res_cout=alu_p[3], compute res_zero from the full result, set res_valid=1, go to HOLD.
- Carry and mode handling: the carry chain is transparent. The sequencer never interprets S/M and forwards alu_p[3] even when M=1.
- Latency: the accept edge is cycle 0. Slices occupy cycles 1..NSLICE. res_valid rises on the edge ending slice NSLICE-1. Total is NSLICE+1 edges (5 for WIDTH=16).
- HOLD:
  - res_* are stable while res_valid=1 and res_ready=0.
  - On res_ready=1: res_valid=0, go to IDLE. The next command can be accepted on the following cycle; no same-cycle turnaround.
  - alu_* outputs hold their last values in HOLD and IDLE.
- Boundaries:
  - cmd_valid during RUN or HOLD is ignored because cmd_ready=0. The command must be held by its source.
  - Changes on cmd_* after acceptance have no effect.
  - rst asserted mid-RUN or in HOLD: return to reset values on the next edge. The partial result is discarded and res_valid never pulses.
  - WIDTH=4: a single RUN cycle.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, HOLD=2'd2;
  - SLICE_W=4;
  - ALU function code constants used by the bench: ALU_ADD S=4'b1001/M=0, ALU_XOR S=4'b0110/M=1.
- No sub-module. The ALU slice stays outside and is instantiated next to the sequencer by the integrator/bench.

Test Plan:
The bench pairs the sequencer with a behavioural slice model: M=0,S=1001 gives R=A+B+Pin with P[3]=carry; M=1,S=0110 gives R=A^B with P[3]=0.
- Add: A=16'h0FFF, B=16'h0001, cin=0 -> res_r=16'h1000, res_cout=0, res_zero=0. res_valid goes high exactly 5 edges after acceptance. The carry ripples across slices 0..2.
- Add with overflow: A=16'hFFFF, B=16'h0001, cin=0 -> res_r=16'h0000, res_cout=1, res_zero=1.
- XOR logic mode: A=16'hA5A5, B=16'h5A5A -> res_r=16'hFFFF, res_cout=0. Also check alu_m=1 and alu_s=0110 on every RUN cycle.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid and toggle cmd_valid with new operands -> res_* unchanged, cmd_ready=0 throughout. Command accepted only one cycle after the res_ready handshake.
- Reset mid-operation: assert rst on the 3rd RUN cycle -> next edge: state IDLE, res_valid=0, res_r=0, cmd_ready=1. A following add 16'h0002+16'h0003 returns 16'h0005.
- Back-to-back: two adds issued with res_ready tied high -> results 16'h1111+16'h2222=16'h3333, then 16'h8000+16'h8000=16'h0000 with res_cout=1. Exactly one res_valid pulse per command.
